// File: rtl/uart_autobaud_detector.sv
// ----------------------------------------------------------------------------
// uart_autobaud_detector
//
// Measures the bit period of an incoming UART 0x55 ('U') sync character and
// produces both the raw period and a half-tick divisor in the form the baud
// rate generator's STOPCOUNTER expects. Sits on the rx path ahead of the
// receiver; a controller arms it with a rising edge on ena and loads div_out
// into the generator once locked is set.
//
// 0x55 sent 8N1 (LSB first) gives falling edges at bit times 0,2,4,6,8, so the
// four intervals between the five falling edges add up to eight bit times.
// The stop bit's rising edge, one bit after the fifth falling edge, confirms
// the frame.
//
// Ports
//   clock      in   1      system clock, rising edge
//   nreset     in   1      asynchronous reset, active low
//   ena        in   1      arm level; rising edge starts one detection,
//                          low aborts a detection in progress
//   rx         in   1      asynchronous serial line, idle high
//   busy       out  1      detection in progress
//   valid      out  1      one-cycle pulse when a measurement completes
//   locked     out  1      result valid; held until the next arm
//   error      out  1      last attempt failed; held until the next arm
//   bit_period out  CNT_W  measured cycles per bit, (T+4)>>3
//   div_out    out  CNT_W  (T + 8*OVERSAMPLING) >> log2(16*OVERSAMPLING)
//   state_dbg  out  3      current FSM state encoding (observation only)
//
// Output contract: valid is a single-cycle strobe with no back-pressure;
// bit_period, div_out and locked are already updated in the cycle valid is
// high and stay stable until the next successful measurement (bit_period,
// div_out) or the next arm (locked, error).
// ----------------------------------------------------------------------------
module uart_autobaud_detector #(
    parameter int CLOCK_INPUT  = 50_000_000,
    parameter int OVERSAMPLING = 8,
    parameter int CNT_W        = 24,
    parameter int IDLE_CYCLES  = 64,
    parameter int MIN_PERIOD   = 16,
    parameter int TOL_SHIFT    = 3
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             ena,
    input  logic             rx,
    output logic             busy,
    output logic             valid,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] bit_period,
    output logic [CNT_W-1:0] div_out,
    output logic [2:0]       state_dbg
);

    // Elaboration-time parameter sanity.
    generate
        if (CLOCK_INPUT <= 0 || OVERSAMPLING < 2 ||
            (OVERSAMPLING & (OVERSAMPLING - 1)) != 0) begin : g_bad_param
            $error("uart_autobaud_detector: bad CLOCK_INPUT/OVERSAMPLING");
        end
    endgenerate

    localparam int T_W       = CNT_W + 3;               // holds 8 bit times
    localparam int DIV_SHIFT = $clog2(16 * OVERSAMPLING);
    localparam int IDLE_W    = $clog2(IDLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  MIN_REF   = CNT_W'(2 * MIN_PERIOD);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_IDLE  = 3'd1,
        S_WAIT_START = 3'd2,
        S_MEASURE    = 3'd3,
        S_STOP_CHECK = 3'd4
    } state_t;

    state_t            state;

    // rx synchroniser (rx_meta, rx_s) plus one delay flop for edge detection.
    logic              rx_meta;
    logic              rx_s;
    logic              rx_d;
    logic              ena_q;

    logic [IDLE_W-1:0] idle_cnt;
    logic [CNT_W-1:0]  cnt;         // cycles since the last accepted edge, minus one
    logic [CNT_W-1:0]  ref_period;  // first interval (two bit times)
    logic [T_W-1:0]    total_t;     // running sum of intervals
    logic [1:0]        edge_num;    // intervals accepted so far

    logic              fall;
    logic              rise;
    logic              arm;
    logic [CNT_W-1:0]  interval;
    logic [CNT_W-1:0]  diff;
    logic [CNT_W-1:0]  tol;
    logic [T_W-1:0]    t_next;

    assign fall = rx_d & ~rx_s;
    assign rise = ~rx_d & rx_s;
    assign arm  = ena & ~ena_q;

    // cnt is cleared in the cycle the edge is seen, so the distance to an
    // edge seen now is cnt + 1.
    assign interval = cnt + CNT_W'(1);
    assign diff     = (interval > ref_period) ? (interval - ref_period)
                                              : (ref_period - interval);
    assign tol      = ref_period >> TOL_SHIFT;
    assign t_next   = total_t + {3'b000, interval};

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= S_IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            ena_q      <= 1'b0;
            idle_cnt   <= '0;
            cnt        <= '0;
            ref_period <= '0;
            total_t    <= '0;
            edge_num   <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            error      <= 1'b0;
            bit_period <= '0;
            div_out    <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            ena_q   <= ena;
            valid   <= 1'b0;

            if (state != S_IDLE && !ena) begin
                // Abort: return quietly, no result and no error.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Edge-armed: a level held high arms only once.
                        if (arm) begin
                            state    <= S_WAIT_IDLE;
                            locked   <= 1'b0;
                            error    <= 1'b0;
                            idle_cnt <= '0;
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (rx_s) begin
                            if (idle_cnt == IDLE_LAST) begin
                                state <= S_WAIT_START;
                            end else begin
                                idle_cnt <= idle_cnt + IDLE_W'(1);
                            end
                        end else begin
                            idle_cnt <= '0;
                        end
                    end

                    S_WAIT_START: begin
                        if (fall) begin
                            state    <= S_MEASURE;
                            cnt      <= '0;
                            total_t  <= '0;
                            edge_num <= '0;
                        end
                    end

                    S_MEASURE: begin
                        if (cnt == CNT_MAX) begin
                            // Line stuck: counter saturated.
                            state  <= S_IDLE;
                            error  <= 1'b1;
                            locked <= 1'b0;
                        end else if (fall) begin
                            if (edge_num == 2'd0) begin
                                if (interval < MIN_REF) begin
                                    state  <= S_IDLE;
                                    error  <= 1'b1;
                                    locked <= 1'b0;
                                end else begin
                                    ref_period <= interval;
                                    total_t    <= t_next;
                                    edge_num   <= 2'd1;
                                    cnt        <= '0;
                                end
                            end else if (diff > tol) begin
                                state  <= S_IDLE;
                                error  <= 1'b1;
                                locked <= 1'b0;
                            end else begin
                                total_t <= t_next;
                                cnt     <= '0;
                                if (edge_num == 2'd3) begin
                                    state <= S_STOP_CHECK;
                                end else begin
                                    edge_num <= edge_num + 2'd1;
                                end
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    S_STOP_CHECK: begin
                        // The stop bit must rise within one reference
                        // interval of the fifth falling edge.
                        if (rise) begin
                            bit_period <= CNT_W'(({1'b0, total_t} + (T_W + 1)'(4)) >> 3);
                            div_out    <= CNT_W'(({1'b0, total_t} +
                                                  (T_W + 1)'(8 * OVERSAMPLING)) >> DIV_SHIFT);
                            valid      <= 1'b1;
                            locked     <= 1'b1;
                            state      <= S_IDLE;
                        end else if (interval >= ref_period) begin
                            state  <= S_IDLE;
                            error  <= 1'b1;
                            locked <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_detector.sv
// ----------------------------------------------------------------------------
// tb_uart_autobaud_detector
//
// Directed bench for uart_autobaud_detector. Each detection attempt pushes
// its expected outcome {locked, error, valid count, bit_period, div_out}
// into exp_q; a monitor pops and compares whenever busy falls (the DUT has
// finished an attempt, successfully, with an error, by abort or by reset).
// Bit edges are placed at ceil(k * period) for fractional periods given in
// hundredths of a clock cycle, which gives these hand-computed results:
//   115200 (434.03): falls at 0,869,1737,2605,3473 -> T=3473,
//                    bit_period=3477>>3=434, div_out=3537>>7=27
//   9600 (5208.33):  falls at 0,10417,20834,31250,41667 -> T=41667,
//                    bit_period=41671>>3=5208, div_out=41731>>7=326
// ----------------------------------------------------------------------------
module tb_uart_autobaud_detector;

    localparam int CNT_W = 24;
    localparam int SB_W  = 4 + 2 * CNT_W;

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             nreset;
    logic             ena;
    logic             rx;
    logic             busy;
    logic             valid;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] bit_period;
    logic [CNT_W-1:0] div_out;
    logic [2:0]       state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_autobaud_detector #(
        .CLOCK_INPUT (50_000_000),
        .OVERSAMPLING(8),
        .CNT_W       (CNT_W),
        .IDLE_CYCLES (64),
        .MIN_PERIOD  (16),
        .TOL_SHIFT   (3)
    ) dut (
        .clock     (clk),
        .nreset    (nreset),
        .ena       (ena),
        .rx        (rx),
        .busy      (busy),
        .valid     (valid),
        .locked    (locked),
        .error     (error),
        .bit_period(bit_period),
        .div_out   (div_out),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    int              total = 0;
    int              bad   = 0;
    logic [1:0]      vcnt  = 2'd0;
    logic            busy_q = 1'b0;

    function automatic logic [SB_W-1:0] pack(input logic l, input logic e,
                                             input logic [1:0] v,
                                             input logic [CNT_W-1:0] bp,
                                             input logic [CNT_W-1:0] dv);
        return {l, e, v, bp, dv};
    endfunction

    task automatic check(input string name, input logic [SB_W-1:0] act,
                         input logic [SB_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy && !busy_q) vcnt = 2'd0;
        if (valid && vcnt != 2'd3) vcnt = vcnt + 2'd1;
        if (!busy && busy_q) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: got %h expected none",
                         pack(locked, error, vcnt, bit_period, div_out));
            end else begin
                check("outcome", pack(locked, error, vcnt, bit_period, div_out),
                      exp_q.pop_front());
            end
        end
        busy_q = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        ena = 1'b0;
        step();
        step();
        ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("arm_busy", SB_W'(busy), SB_W'(1));
        check("arm_clears_flags", SB_W'({locked, error}), SB_W'(0));
        rx = 1'b1;
        repeat (80) step();
    endtask

    // Sends one 8N1 frame; period_x100 is the bit period in hundredths of a
    // cycle. Stops early after max_c cycles (partial frames).
    task automatic send_frame(input logic [7:0] data, input int period_x100,
                              input int max_c);
        int         idx;
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int c = 0; c < max_c; c++) begin
            idx = (c * 100) / period_x100;
            if (idx >= 10) break;
            rx = frame[idx];
            step();
        end
        rx = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nreset = 1'b0;
        ena    = 1'b0;
        rx     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", pack(locked, error, {1'b0, valid}, bit_period, div_out),
              pack(1'b0, 1'b0, 2'd0, '0, '0));
        check("reset_busy", SB_W'(busy), SB_W'(0));
        @(posedge clk);
        #1;
        nreset = 1'b1;
        step();

        // 1: 0x55 at 115200
        arm();
        exp_q.push_back(pack(1'b1, 1'b0, 2'd1, CNT_W'(434), CNT_W'(27)));
        send_frame(8'h55, 43403, 10000);
        drain(2000);
        // ena still high: must not re-arm
        repeat (10) step();
        check("edge_armed_idle", SB_W'({busy, locked}), SB_W'(2'b01));

        // 2: 0x55 at 9600
        arm();
        exp_q.push_back(pack(1'b1, 1'b0, 2'd1, CNT_W'(5208), CNT_W'(326)));
        send_frame(8'h55, 520833, 60000);
        drain(2000);

        // 3: 0x57 at 115200 -> interval mismatch, outputs retained
        arm();
        exp_q.push_back(pack(1'b0, 1'b1, 2'd0, CNT_W'(5208), CNT_W'(326)));
        send_frame(8'h57, 43403, 10000);
        drain(2000);

        // 4: two 1-cycle glitches 10 cycles apart -> too short
        arm();
        exp_q.push_back(pack(1'b0, 1'b1, 2'd0, CNT_W'(5208), CNT_W'(326)));
        rx = 1'b0;
        step();
        rx = 1'b1;
        repeat (9) step();
        rx = 1'b0;
        step();
        rx = 1'b1;
        drain(200);

        // 5: abort after the 2nd falling edge, then re-arm and lock
        arm();
        send_frame(8'h55, 43403, 1000);
        exp_q.push_back(pack(1'b0, 1'b0, 2'd0, CNT_W'(5208), CNT_W'(326)));
        ena = 1'b0;
        rx  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_next_cycle", SB_W'({busy, valid, locked, error}), SB_W'(0));
        drain(10);
        arm();
        exp_q.push_back(pack(1'b1, 1'b0, 2'd1, CNT_W'(434), CNT_W'(27)));
        send_frame(8'h55, 43403, 10000);
        drain(2000);

        // 6: reset during MEASURE, then a clean lock
        arm();
        send_frame(8'h55, 43403, 1500);
        exp_q.push_back(pack(1'b0, 1'b0, 2'd0, '0, '0));
        nreset = 1'b0;
        ena    = 1'b0;
        rx     = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_outputs", pack(locked, error, {busy, valid}, bit_period, div_out),
              pack(1'b0, 1'b0, 2'd0, '0, '0));
        @(posedge clk);
        #1;
        nreset = 1'b1;
        drain(10);
        arm();
        exp_q.push_back(pack(1'b1, 1'b0, 2'd1, CNT_W'(434), CNT_W'(27)));
        send_frame(8'h55, 43403, 10000);
        drain(2000);

        // ---------------- report ----------------
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
